// File: rtl/prince_sbox_cms_compress.sv
// rtl/prince_sbox_cms_compress.sv - PRINCE CMS S-box share register + XOR compression, two-stage valid/ready pipe
module prince_sbox_cms_compress #(
    parameter int NBITS = 4,
    parameter int NEXP  = 8,
    parameter int NOUT  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBITS*NEXP-1:0]  in_shares,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBITS*NOUT-1:0]  out_shares,
    output logic [1:0]             occupancy
);

    logic                   r_s1_valid;
    logic                   r_s2_valid;
    logic [NBITS*NEXP-1:0]  r_s1;
    logic [NBITS*NOUT-1:0]  r_s2;
    logic [NBITS*NOUT-1:0]  w_grp;
    logic                   w_s2_load;
    logic                   w_in_fire;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_fire = in_valid && in_ready;

    // Stage 1 is the glitch barrier: every expanded share lands in its own flop
    // before any shares are combined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            r_s1_valid <= w_in_fire || (r_s1_valid && !w_s2_load);
            if (w_in_fire) begin
                r_s1 <= in_shares;
            end
        end
    end

    // Share k of each bit folds into compressed share k mod NOUT.
    always_comb begin
        w_grp = '0;
        for (int b = 0; b < NBITS; b++) begin
            for (int k = 0; k < NEXP; k++) begin
                w_grp[b*NOUT + (k % NOUT)] = w_grp[b*NOUT + (k % NOUT)] ^ r_s1[b*NEXP + k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else begin
            r_s2_valid <= (r_s1_valid && w_s2_load) || (r_s2_valid && !out_ready);
            if (r_s1_valid && w_s2_load) begin
                r_s2 <= w_grp;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_shares = r_s2;
    assign occupancy  = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};

endmodule
